// File: rtl/tagger_deadtime.sv
// Per-channel deadtime filter for the tagger front end.
// Forwards edges one cycle late and blocks edges for a set time after each one it accepts.
module tagger_deadtime #(
   parameter int BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] in_subtimes,
   input  logic            in_edge_detected,
   output logic [BITS-1:0] out_subtimes,
   output logic            out_edge_detected,
   input  logic [15:0]     conf_deadtime
);

   logic [15:0] cnt;
   logic        accept;

   // An edge passes only when no deadtime window is open
   always_comb begin
      accept = in_edge_detected && (cnt == 16'd0);
   end

   // Register outputs; open a new window on accept, else count an open window down to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         out_edge_detected <= 1'b0;
         out_subtimes      <= '0;
         cnt               <= 16'd0;
      end else begin
         out_edge_detected <= accept;
         out_subtimes      <= in_subtimes;
         if (accept)
            cnt <= conf_deadtime;
         else if (cnt != 16'd0)
            cnt <= cnt - 16'd1;
      end
   end

endmodule

// File: tb/tb_tagger_deadtime.sv
// Directed and randomised checks of the deadtime filter.
// Random traffic is compared against a model built on accept timestamps.
module tb_tagger_deadtime;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  in_sub;
   logic        in_edge;
   logic [2:0]  out_sub;
   logic        out_edge;
   logic [15:0] conf;

   int n_chk = 0;
   int n_err = 0;

   tagger_deadtime #(.BITS(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .in_subtimes       (in_sub),
      .in_edge_detected  (in_edge),
      .out_subtimes      (out_sub),
      .out_edge_detected (out_edge),
      .conf_deadtime     (conf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one cycle's inputs, then land 1 time unit after the edge
   task automatic cyc(input logic e, input logic [2:0] s);
      in_edge = e;
      in_sub  = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst     = 1'b1;
      in_edge = 1'b1;
      in_sub  = 3'd7;
      @(posedge clk);
      #1;
      check({tag, "_rst_edge"}, out_edge, 1'b0);
      check({tag, "_rst_sub"}, out_sub, 3'd0);
      rst     = 1'b0;
      in_edge = 1'b0;
   endtask

   // bit i of e = input edge in cycle i; bit i of x = expected output for that input
   task automatic seq(input string tag, input int len,
                      input logic [15:0] n0, input logic [15:0] n1, input int chg,
                      input logic [31:0] e, input logic [31:0] x);
      logic [2:0] s;
      for (int i = 0; i < len; i++) begin
         conf = (i >= chg) ? n1 : n0;
         s    = i[2:0] ^ 3'd5;
         cyc(e[i], s);
         check($sformatf("%s_c%0d", tag, i), out_edge, x[i]);
         if (x[i])
            check($sformatf("%s_sub%0d", tag, i), out_sub, s);
      end
   endtask

   initial begin
      int         last_t;
      logic [15:0] last_n;
      bit         seen;
      logic       e, r, exp_e;
      logic [2:0] s;
      logic [15:0] n;

      rst     = 1'b0;
      in_edge = 1'b0;
      in_sub  = 3'd0;
      conf    = 16'd0;
      @(posedge clk);
      #1;
      do_reset("t1");
      seq("t1", 5, 16'd0, 16'd0, 99, 32'b11111, 32'b11111);

      do_reset("t2");
      seq("t2", 9, 16'd3, 16'd3, 99, 32'b1_1111_1111, 32'b1_0001_0001);

      do_reset("t3");
      seq("t3", 5, 16'd3, 16'd3, 99, 32'b11101, 32'b10001);

      do_reset("t4");
      seq("t4", 14, 16'd10, 16'd1, 2,
          32'b11_1100_0010_0001, 32'b10_1000_0000_0001);

      do_reset("t5");
      conf = 16'd100;
      cyc(1'b1, 3'd2);
      check("t5_acc", out_edge, 1'b1);
      for (int i = 1; i < 20; i++) begin
         cyc(i[0], 3'd1);
         check("t5_drop", out_edge, 1'b0);
      end
      do_reset("t5");
      cyc(1'b1, 3'd6);
      check("t5_post", out_edge, 1'b1);
      check("t5_post_sub", out_sub, 3'd6);

      do_reset("tmax");
      conf = 16'd65535;
      cyc(1'b1, 3'd3);
      check("tmax_acc", out_edge, 1'b1);
      conf = 16'd0;
      for (int i = 1; i <= 300; i++) begin
         cyc(1'b1, 3'd4);
         check("tmax_drop", out_edge, 1'b0);
      end

      do_reset("t6");
      seen   = 1'b0;
      last_t = 0;
      last_n = 16'd0;
      for (int t = 0; t < 5000; t++) begin
         e = ($urandom_range(0, 1) == 1);
         s = 3'($urandom_range(0, 7));
         n = 16'($urandom_range(0, 7));
         r = ($urandom_range(0, 99) == 0);
         if (r) begin
            exp_e = 1'b0;
            seen  = 1'b0;
         end else begin
            exp_e = e && (!seen || (t - last_t) > int'(last_n));
            if (exp_e) begin
               seen   = 1'b1;
               last_t = t;
               last_n = n;
            end
         end
         rst  = r;
         conf = n;
         cyc(e, s);
         check("t6_edge", out_edge, exp_e);
         if (r)
            check("t6_rst_sub", out_sub, 3'd0);
         else if (exp_e)
            check("t6_sub", out_sub, s);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
